// File: rtl/serializer_nto1_hs.sv
// N-to-1 serializer: one-word holding buffer behind a valid/ready handshake, shifts out MSB/LSB first on bit_en ticks.
// Optional even-parity bit after each frame when SER_PARITY_EN is defined.
module serializer_nto1_hs #(
    parameter int WIDTH      = 32,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             bit_en,
    output logic             data_out,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic [CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0]   hold_reg, hold_next;
    logic               hold_valid_reg, hold_valid_next;
    logic               data_out_reg, data_out_next;
    logic               frame_start_reg, frame_start_next;
    logic               done_reg, done_next;
    logic               load;
    logic               frame_end;
    logic               accept;
`ifdef SER_PARITY_EN
    logic               parity_reg, parity_next;
`endif

    // The bit leaving the word next, and the word with that bit consumed.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    assign in_ready    = !hold_valid_reg && !reset;
    assign accept      = in_valid && in_ready;
    assign data_out    = data_out_reg;
    assign frame_start = frame_start_reg;
    assign done        = done_reg;
    assign busy        = (state_reg != IDLE);

    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        bit_cnt_next     = bit_cnt_reg;
        hold_next        = hold_reg;
        hold_valid_next  = hold_valid_reg;
        data_out_next    = data_out_reg;
        frame_start_next = 1'b0;
        done_next        = 1'b0;
        load             = 1'b0;
        frame_end        = 1'b0;
`ifdef SER_PARITY_EN
        parity_next      = parity_reg;
`endif
        if (bit_en) begin
            case (state_reg)
                IDLE: load = hold_valid_reg;
                SHIFT: begin
                    if (bit_cnt_reg == LAST_BIT) begin
`ifdef SER_PARITY_EN
                        state_next    = PAR;
                        data_out_next = parity_reg;
`else
                        frame_end     = 1'b1;
`endif
                    end else begin
                        data_out_next = first_bit(shift_reg);
                        shift_next    = advance(shift_reg);
                        bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
                    end
                end
`ifdef SER_PARITY_EN
                PAR: frame_end = 1'b1;
`endif
                default: state_next = IDLE;
            endcase
        end

        // A pending word chains straight into the next frame without an idle bit.
        if (frame_end) begin
            if (hold_valid_reg) begin
                load = 1'b1;
            end else begin
                state_next    = IDLE;
                data_out_next = IDLE_LEVEL;
                done_next     = 1'b1;
            end
        end

        if (load) begin
            state_next       = SHIFT;
            data_out_next    = first_bit(hold_reg);
            shift_next       = advance(hold_reg);
            bit_cnt_next     = '0;
            frame_start_next = 1'b1;
            hold_valid_next  = 1'b0;
`ifdef SER_PARITY_EN
            parity_next      = ^hold_reg;
`endif
        end

        if (accept) begin
            hold_next       = data_in;
            hold_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            hold_reg        <= '0;
            hold_valid_reg  <= 1'b0;
            data_out_reg    <= IDLE_LEVEL;
            frame_start_reg <= 1'b0;
            done_reg        <= 1'b0;
`ifdef SER_PARITY_EN
            parity_reg      <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            bit_cnt_reg     <= bit_cnt_next;
            hold_reg        <= hold_next;
            hold_valid_reg  <= hold_valid_next;
            data_out_reg    <= data_out_next;
            frame_start_reg <= frame_start_next;
            done_reg        <= done_next;
`ifdef SER_PARITY_EN
            parity_reg      <= parity_next;
`endif
        end
    end

endmodule
